epl_column_access_mux: RTL and testbench

Parametrised column-access engine for the EPLFFRAM array: scatters a TWORD_WIDTH codeword onto every MUX-th bit-line for writes and gathers it back for reads, for any column-mux ratio. It sits between the word-level controller and the column drivers / sense amplifiers. It extends the fixed MUX=2 write-only path with:
- a multi-cycle write pulse,
- a read path with configurable sense latency,
- a valid/ready handshake,
- illegal-select detection.

---
 rtl/epl_column_access_mux.sv | 171 +++++++++++++++++
 tb/tb_epl_column_access_mux.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/epl_column_access_mux.sv
// Column-access engine for the EPLFFRAM array. A write scatters the codeword onto every
// MUX-th bit-line, and a read gathers it back from the sense amplifiers.
module epl_column_access_mux #(
    parameter  int TWORD_WIDTH = 7,
    parameter  int MUX         = 2,
    parameter  int WE_CYC      = 1,
    parameter  int RD_LAT      = 2,
    localparam int COLUMN      = TWORD_WIDTH * MUX
) (
    input  logic                   pClk_i,
    input  logic                   nRst_i,
    input  logic                   pValid_i,
    output logic                   pReady_o,
    input  logic                   pWr_i,
    input  logic [MUX-1:0]         pAcy_i,
    input  logic [TWORD_WIDTH-1:0] pCodeword_i,
    output logic [COLUMN-1:0]      pWe_o,
    output logic [COLUMN-1:0]      pDi_o,
    output logic                   pRe_o,
    input  logic [COLUMN-1:0]      pDo_i,
    output logic [TWORD_WIDTH-1:0] pRdata_o,
    output logic                   pRvalid_o,
    output logic                   pErr_o,
    output logic [MUX-1:0]         pAcy1_o
);

    localparam int CNT_MAX = (WE_CYC > RD_LAT) ? WE_CYC : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [COLUMN-1:0]      we_q, we_d, di_q, di_d;
    logic                   re_q, re_d;
    logic [TWORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   err_q, err_d;
    logic [MUX-1:0]         acy1_q, acy1_d;
    logic                   ready_q, ready_d;

    logic                   accept;
    logic                   legal_sel;
    logic [COLUMN-1:0]      wr_mask;
    logic [COLUMN-1:0]      wr_data;
    logic [TWORD_WIDTH-1:0] gathered;

    assign accept    = pValid_i && ready_q;
    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
    assign legal_sel = (pAcy_i != '0) && ((pAcy_i & (pAcy_i - MUX'(1))) == '0);

    // Codeword bit i maps to column i*MUX+k for the one-hot select bit k.
    always_comb begin
        wr_mask = '0;
        wr_data = '0;
        for (int i = 0; i < TWORD_WIDTH; i++) begin
            for (int j = 0; j < MUX; j++) begin
                wr_mask[i*MUX+j] = pAcy_i[j];
                wr_data[i*MUX+j] = pCodeword_i[i] & pAcy_i[j];
            end
        end
    end

    always_comb begin
        gathered = '0;
        for (int i = 0; i < TWORD_WIDTH; i++) begin
            gathered[i] = |(pDo_i[i*MUX +: MUX] & acy1_q);
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        di_d     = di_q;
        re_d     = re_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        acy1_d   = acy1_q;
        ready_d  = ready_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!legal_sel) begin
                        err_d = 1'b1;
                    end else begin
                        acy1_d  = pAcy_i;
                        ready_d = 1'b0;
                        if (pWr_i) begin
                            we_d    = wr_mask;
                            di_d    = wr_data;
                            cnt_d   = WE_LOAD;
                            state_d = WRITE;
                        end else begin
                            re_d    = 1'b1;
                            cnt_d   = RD_LOAD;
                            state_d = READ;
                        end
                    end
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    we_d    = '0;
                    di_d    = '0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    rdata_d  = gathered;
                    rvalid_d = 1'b1;
                    re_d     = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge pClk_i) begin
        if (!nRst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= '0;
            di_q     <= '0;
            re_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            acy1_q   <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            di_q     <= di_d;
            re_q     <= re_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            acy1_q   <= acy1_d;
            ready_q  <= ready_d;
        end
    end

    assign pReady_o  = ready_q;
    assign pWe_o     = we_q;
    assign pDi_o     = di_q;
    assign pRe_o     = re_q;
    assign pRdata_o  = rdata_q;
    assign pRvalid_o = rvalid_q;
    assign pErr_o    = err_q;
    assign pAcy1_o   = acy1_q;

endmodule

// File: tb/tb_epl_column_access_mux.sv
// Testbench for epl_column_access_mux. Three instances cover MUX ratios of 2, 4 and 8, and a
// queue holds the expected array activity until each instance produces it.
module tb_epl_column_access_mux;

    localparam int NC = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        valid [NC];
    logic        wr    [NC];
    logic [7:0]  acy   [NC];
    logic [7:0]  cw    [NC];
    logic [63:0] dout  [NC];

    wire ready  [NC];
    wire re     [NC];
    wire rvalid [NC];
    wire err    [NC];

    wire [13:0] we0, di0;
    wire [15:0] we1, di1;
    wire [39:0] we2, di2;
    wire [6:0]  rd0;
    wire [3:0]  rd1;
    wire [4:0]  rd2;
    wire [1:0]  sel0;
    wire [3:0]  sel1;
    wire [7:0]  sel2;

    logic [63:0] we_v [NC], di_v [NC], rd_v [NC], sel_v [NC];
    always_comb begin
        we_v[0] = 64'(we0);  we_v[1] = 64'(we1);  we_v[2] = 64'(we2);
        di_v[0] = 64'(di0);  di_v[1] = 64'(di1);  di_v[2] = 64'(di2);
        rd_v[0] = 64'(rd0);  rd_v[1] = 64'(rd1);  rd_v[2] = 64'(rd2);
        sel_v[0] = 64'(sel0); sel_v[1] = 64'(sel1); sel_v[2] = 64'(sel2);
    end

    epl_column_access_mux #(.TWORD_WIDTH(7), .MUX(2), .WE_CYC(1), .RD_LAT(2)) dut0 (
        .pClk_i(clk), .nRst_i(rst_n), .pValid_i(valid[0]), .pReady_o(ready[0]),
        .pWr_i(wr[0]), .pAcy_i(acy[0][1:0]), .pCodeword_i(cw[0][6:0]),
        .pWe_o(we0), .pDi_o(di0), .pRe_o(re[0]), .pDo_i(dout[0][13:0]),
        .pRdata_o(rd0), .pRvalid_o(rvalid[0]), .pErr_o(err[0]), .pAcy1_o(sel0));

    epl_column_access_mux #(.TWORD_WIDTH(4), .MUX(4), .WE_CYC(3), .RD_LAT(2)) dut1 (
        .pClk_i(clk), .nRst_i(rst_n), .pValid_i(valid[1]), .pReady_o(ready[1]),
        .pWr_i(wr[1]), .pAcy_i(acy[1][3:0]), .pCodeword_i(cw[1][3:0]),
        .pWe_o(we1), .pDi_o(di1), .pRe_o(re[1]), .pDo_i(dout[1][15:0]),
        .pRdata_o(rd1), .pRvalid_o(rvalid[1]), .pErr_o(err[1]), .pAcy1_o(sel1));

    epl_column_access_mux #(.TWORD_WIDTH(5), .MUX(8), .WE_CYC(2), .RD_LAT(1)) dut2 (
        .pClk_i(clk), .nRst_i(rst_n), .pValid_i(valid[2]), .pReady_o(ready[2]),
        .pWr_i(wr[2]), .pAcy_i(acy[2][7:0]), .pCodeword_i(cw[2][4:0]),
        .pWe_o(we2), .pDi_o(di2), .pRe_o(re[2]), .pDo_i(dout[2][39:0]),
        .pRdata_o(rd2), .pRvalid_o(rvalid[2]), .pErr_o(err[2]), .pAcy1_o(sel2));

    function automatic int w_of(int c);   return (c == 0) ? 7 : (c == 1) ? 4 : 5; endfunction
    function automatic int m_of(int c);   return (c == 0) ? 2 : (c == 1) ? 4 : 8; endfunction
    function automatic int wcy_of(int c); return (c == 0) ? 1 : (c == 1) ? 3 : 2; endfunction
    function automatic int rlat_of(int c); return (c == 0) ? 2 : (c == 1) ? 2 : 1; endfunction

    // Reference mapping: codeword bit i <-> column i*m+k for select bit k.
    function automatic logic [63:0] mask_of(int c, logic [7:0] a);
        logic [63:0] r = '0;
        for (int i = 0; i < w_of(c); i++)
            for (int j = 0; j < m_of(c); j++) r[i*m_of(c)+j] = a[j];
        return r;
    endfunction

    function automatic logic [63:0] scat_of(int c, logic [7:0] d, logic [7:0] a);
        logic [63:0] r = '0;
        for (int i = 0; i < w_of(c); i++)
            for (int j = 0; j < m_of(c); j++) r[i*m_of(c)+j] = d[i] & a[j];
        return r;
    endfunction

    function automatic logic [7:0] gath_of(int c, logic [63:0] q, logic [7:0] a);
        logic [7:0] r = '0;
        for (int i = 0; i < w_of(c); i++)
            for (int j = 0; j < m_of(c); j++) if (a[j]) r[i] = q[i*m_of(c)+j];
        return r;
    endfunction

    typedef struct {
        int          c;
        logic [63:0] we;
        logic [63:0] di;
        logic [7:0]  rd;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_txn(input int c, input logic [7:0] a, input logic [7:0] d,
                             input logic [63:0] exp_we, input logic [63:0] exp_di);
        exp_t e;
        int   n;
        @(negedge clk);
        check("wr_ready_before", 64'(ready[c]), 64'd1);
        valid[c] = 1'b1; wr[c] = 1'b1; acy[c] = a; cw[c] = d;
        e.c = c; e.we = exp_we; e.di = exp_di; e.rd = '0;
        sb.push_back(e);
        @(negedge clk);
        valid[c] = 1'b0;
        e = sb.pop_front();
        n = 0;
        while (we_v[c] != '0 && n < 64) begin
            check("wr_we", we_v[c], e.we);
            check("wr_di", di_v[c], e.di);
            check("wr_busy", 64'(ready[c]), 64'd0);
            n++;
            @(negedge clk);
        end
        check("wr_pulse_len", 64'(n), 64'(wcy_of(c)));
        check("wr_we_off", we_v[c], 64'd0);
        check("wr_di_off", di_v[c], 64'd0);
        check("wr_ready_after", 64'(ready[c]), 64'd1);
    endtask

    task automatic read_txn(input int c, input logic [7:0] a, input logic [63:0] q,
                            input logic [7:0] exp_rd);
        exp_t e;
        int   n;
        @(negedge clk);
        check("rd_ready_before", 64'(ready[c]), 64'd1);
        valid[c] = 1'b1; wr[c] = 1'b0; acy[c] = a; dout[c] = q;
        e.c = c; e.we = '0; e.di = '0; e.rd = exp_rd;
        sb.push_back(e);
        @(negedge clk);
        valid[c] = 1'b0;
        n = 0;
        while (re[c] && !rvalid[c] && n < 64) begin
            check("rd_busy", 64'(ready[c]), 64'd0);
            n++;
            @(negedge clk);
        end
        check("rd_re_len", 64'(n), 64'(rlat_of(c)));
        check("rd_rvalid", 64'(rvalid[c]), 64'd1);
        e = sb.pop_front();
        check("rd_data", rd_v[c], 64'(e.rd));
        check("rd_re_off", 64'(re[c]), 64'd0);
        check("rd_ready_after", 64'(ready[c]), 64'd1);
        @(negedge clk);
        check("rd_rvalid_pulse", 64'(rvalid[c]), 64'd0);
        check("rd_data_hold", rd_v[c], 64'(e.rd));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  a, d;
        logic [63:0] q, cmask;
        int          seen;

        for (int c = 0; c < NC; c++) begin
            valid[c] = 1'b0; wr[c] = 1'b0; acy[c] = '0; cw[c] = '0; dout[c] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            check("rst_ready", 64'(ready[c]), 64'd1);
            check("rst_we", we_v[c], 64'd0);
            check("rst_di", di_v[c], 64'd0);
            check("rst_re", 64'(re[c]), 64'd0);
            check("rst_rvalid", 64'(rvalid[c]), 64'd0);
            check("rst_err", 64'(err[c]), 64'd0);
            check("rst_rdata", rd_v[c], 64'd0);
            check("rst_sel", sel_v[c], 64'd0);
        end
        rst_n = 1'b1;

        // MUX=2: both select lanes for write, then reads of the 7'h7F / 7'h00 patterns.
        write_txn(0, 8'h01, 8'h55, 64'h1555, 64'h1111);
        write_txn(0, 8'h02, 8'h55, 64'h2AAA, 64'h2222);
        read_txn(0, 8'h02, 64'h2AAA, 8'h7F);
        read_txn(0, 8'h02, 64'h1555, 8'h00);

        // Illegal selects back to back; the last legal select (2'b10) must be retained.
        @(negedge clk);
        valid[0] = 1'b1; wr[0] = 1'b1; acy[0] = 8'h03; cw[0] = 8'h7F;
        @(negedge clk);
        acy[0] = 8'h00;
        check("ill11_err", 64'(err[0]), 64'd1);
        check("ill11_ready", 64'(ready[0]), 64'd1);
        check("ill11_we", we_v[0], 64'd0);
        check("ill11_re", 64'(re[0]), 64'd0);
        check("ill11_sel", sel_v[0], 64'h2);
        @(negedge clk);
        valid[0] = 1'b0;
        check("ill00_err", 64'(err[0]), 64'd1);
        check("ill00_we", we_v[0], 64'd0);
        check("ill00_re", 64'(re[0]), 64'd0);
        check("ill00_sel", sel_v[0], 64'h2);
        @(negedge clk);
        check("ill_err_pulse", 64'(err[0]), 64'd0);

        // MUX=4, WE_CYC=3 with pValid_i held: second accept lands on the 4th edge.
        @(negedge clk);
        valid[1] = 1'b1; wr[1] = 1'b1; acy[1] = 8'h04; cw[1] = 8'h05;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_we", we_v[1], 64'h4444);
            check("hold_di", di_v[1], 64'h0404);
            check("hold_busy", 64'(ready[1]), 64'd0);
        end
        @(negedge clk);
        check("hold_we_gap", we_v[1], 64'd0);
        check("hold_ready_gap", 64'(ready[1]), 64'd1);
        @(negedge clk);
        valid[1] = 1'b0;
        check("hold_reaccept", we_v[1], 64'h4444);
        repeat (3) @(negedge clk);
        check("hold_we_end", we_v[1], 64'd0);
        check("hold_ready_end", 64'(ready[1]), 64'd1);

        // Reset in the second cycle of a WE_CYC=3 write.
        @(negedge clk);
        valid[1] = 1'b1; wr[1] = 1'b1; acy[1] = 8'h01; cw[1] = 8'h0F;
        @(negedge clk);
        valid[1] = 1'b0;
        check("rstw_we_pre", we_v[1], 64'h1111);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw_we", we_v[1], 64'd0);
        check("rstw_di", di_v[1], 64'd0);
        check("rstw_ready", 64'(ready[1]), 64'd1);

        // Reset while a read is in flight: no read strobe may follow.
        @(negedge clk);
        valid[0] = 1'b1; wr[0] = 1'b0; acy[0] = 8'h02; dout[0] = 64'h2AAA;
        @(negedge clk);
        valid[0] = 1'b0;
        check("rstr_re_pre", 64'(re[0]), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstr_re", 64'(re[0]), 64'd0);
        check("rstr_ready", 64'(ready[0]), 64'd1);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rvalid[0]) seen++;
        end
        check("rstr_no_rvalid", 64'(seen), 64'd0);
        check("rstr_rdata", rd_v[0], 64'd0);

        // Random legal traffic on every MUX ratio against the reference mapping.
        for (int c = 0; c < NC; c++) begin
            cmask = (64'd1 << (w_of(c) * m_of(c))) - 64'd1;
            for (int t = 0; t < 14; t++) begin
                a = 8'(1 << $urandom_range(m_of(c) - 1, 0));
                d = 8'($urandom) & 8'((1 << w_of(c)) - 1);
                if ($urandom_range(1, 0) == 1) begin
                    write_txn(c, a, d, mask_of(c, a), scat_of(c, d, a));
                end else begin
                    q = {$urandom, $urandom} & cmask;
                    read_txn(c, a, q, gath_of(c, q, a));
                end
            end
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
